// File: rtl/press_timer_if.sv
`default_nettype none
// ============================================================================
// Module      : press_timer_if
// Description : Button-side and consumer-side signal bundle of press_timer.
//               The slave modport is the timer itself. The master modport is
//               the board/consumer side that drives the button and freeze.
// Revision    : 1.0 - initial release
// ============================================================================
interface press_timer_if;
    logic       key_in;
    logic       freeze;
    logic       is_pressing;
    logic [3:0] press_time;
    logic       release_pulse;

    modport slave (
        input  key_in,
        input  freeze,
        output is_pressing,
        output press_time,
        output release_pulse
    );

    modport master (
        output key_in,
        output freeze,
        input  is_pressing,
        input  press_time,
        input  release_pulse
    );
endinterface
`default_nettype wire

// File: rtl/press_timer.sv
`default_nettype none
// ============================================================================
// Module      : press_timer
// Description : Synchronises and debounces the raw jump button, then measures
//               how long an accepted press is held. The result is a 4-bit
//               charge level that saturates at 15. Presses that begin while
//               freeze is high are rejected until the key is released.
// Revision    : 1.0 - initial release
// ============================================================================
module press_timer #(
    parameter int DEBOUNCE_CYC = 500000,
    parameter int STEP_CYC     = 10000000
) (
    input  wire logic    clk,
    input  wire logic    rst,      // asynchronous, active-low
    press_timer_if.slave bus
);

    localparam int c_DB_W   = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
    localparam int c_STEP_W = (STEP_CYC > 1) ? $clog2(STEP_CYC) : 1;

    localparam logic [c_DB_W-1:0]   c_DB_LAST   = c_DB_W'(DEBOUNCE_CYC - 1);
    localparam logic [c_STEP_W-1:0] c_STEP_LAST = c_STEP_W'(STEP_CYC - 1);

    localparam logic [1:0] c_IDLE     = 2'd0;
    localparam logic [1:0] c_CHARGE   = 2'd1;
    localparam logic [1:0] c_WAIT_REL = 2'd2;

    logic                r_key_meta;
    logic                r_key_s;
    logic                r_key_db;
    logic [c_DB_W-1:0]   r_db_cnt;
    logic [1:0]          r_state;
    logic [c_STEP_W-1:0] r_step_cnt;
    logic                r_is_pressing;
    logic                r_release_pulse;
    logic [3:0]          r_press_time;

    // Two-flop synchroniser for the asynchronous button input.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_key_meta <= 1'b0;
            r_key_s    <= 1'b0;
        end else begin
            r_key_meta <= bus.key_in;
            r_key_s    <= r_key_meta;
        end
    end

    // Debouncer: key_db follows key_s only after DEBOUNCE_CYC consecutive differing samples.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_db_cnt <= '0;
            r_key_db <= 1'b0;
        end else if (r_key_s == r_key_db) begin
            r_db_cnt <= '0;
        end else if (r_db_cnt == c_DB_LAST) begin
            r_db_cnt <= '0;
            r_key_db <= r_key_s;
        end else begin
            r_db_cnt <= r_db_cnt + c_DB_W'(1);
        end
    end

    // Press FSM: accept, charge and release. The step counter still runs on
    // the release cycle so that the final step is not lost.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state         <= c_IDLE;
            r_step_cnt      <= '0;
            r_is_pressing   <= 1'b0;
            r_release_pulse <= 1'b0;
            r_press_time    <= 4'd0;
        end else begin
            r_release_pulse <= 1'b0;
            case (r_state)
                c_IDLE: begin
                    // In IDLE key_db is always low beforehand, so a high level is a rise.
                    if (r_key_db) begin
                        if (bus.freeze) begin
                            r_state <= c_WAIT_REL;
                        end else begin
                            r_state       <= c_CHARGE;
                            r_press_time  <= 4'd1;
                            r_step_cnt    <= '0;
                            r_is_pressing <= 1'b1;
                        end
                    end
                end
                c_CHARGE: begin
                    if (r_step_cnt == c_STEP_LAST) begin
                        r_step_cnt <= '0;
                        if (r_press_time != 4'd15) begin
                            r_press_time <= r_press_time + 4'd1;
                        end
                    end else begin
                        r_step_cnt <= r_step_cnt + c_STEP_W'(1);
                    end
                    if (!r_key_db) begin
                        r_state         <= c_IDLE;
                        r_is_pressing   <= 1'b0;
                        r_release_pulse <= 1'b1;
                    end
                end
                c_WAIT_REL: begin
                    // A rejected press must be fully released before a new one counts.
                    if (!r_key_db) begin
                        r_state <= c_IDLE;
                    end
                end
                default: begin
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

    assign bus.is_pressing   = r_is_pressing;
    assign bus.press_time    = r_press_time;
    assign bus.release_pulse = r_release_pulse;

endmodule
`default_nettype wire

// File: tb/tb_press_timer.sv
`default_nettype none
// ============================================================================
// Module      : tb_press_timer
// Description : Directed bench for press_timer with a cycle-level reference
//               model of the button-to-charge behaviour.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_press_timer;

    localparam int DB   = 4;
    localparam int STEP = 8;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_pass;
    bit   done;
    bit   cmp_en;

    press_timer_if u_if ();

    press_timer #(
        .DEBOUNCE_CYC (DB),
        .STEP_CYC     (STEP)
    ) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (u_if)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input int got, input int exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
        end
    endtask

    // Reference model: key history -> debounced level -> press bookkeeping.
    bit       m_meta, m_ks, m_db;
    int       m_run;
    bit       m_press, m_rej, m_pulse;
    int       m_n;
    int       m_pt;

    initial begin
        forever begin
            @(posedge clk or negedge rst);
            if (!rst) begin
                m_meta = 0; m_ks = 0; m_db = 0; m_run = 0;
                m_press = 0; m_rej = 0; m_pulse = 0; m_n = 0; m_pt = 0;
            end else begin
                m_pulse = 0;
                if (m_press) begin
                    m_n++;
                    m_pt = (1 + m_n / STEP > 15) ? 15 : 1 + m_n / STEP;
                    if (!m_db) begin
                        m_press = 0;
                        m_pulse = 1;
                    end
                end else if (m_rej) begin
                    if (!m_db) m_rej = 0;
                end else if (m_db) begin
                    if (u_if.freeze) begin
                        m_rej = 1;
                    end else begin
                        m_press = 1;
                        m_n = 0;
                        m_pt = 1;
                    end
                end
                if (m_ks != m_db) begin
                    m_run++;
                    if (m_run == DB) begin
                        m_db = m_ks;
                        m_run = 0;
                    end
                end else begin
                    m_run = 0;
                end
                m_ks = m_meta;
                m_meta = u_if.key_in;
            end
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    initial begin
        forever begin
            @(negedge clk);
            if (cmp_en && !done) begin
                check("is_pressing", int'(u_if.is_pressing), int'(m_press));
                check("press_time", int'(u_if.press_time), m_pt);
                check("release_pulse", int'(u_if.release_pulse), int'(m_pulse));
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        done     = 0;
        cmp_en   = 0;
        rst      = 1'b0;
        u_if.key_in = 1'b0;
        u_if.freeze = 1'b0;
        tick(1);
        cmp_en = 1;

        // Reset held with the key toggling: outputs stay at zero.
        for (int i = 0; i < 10; i++) begin
            u_if.key_in = ~u_if.key_in;
            tick(1);
        end
        check("rst_is_pressing", int'(u_if.is_pressing), 0);
        check("rst_press_time", int'(u_if.press_time), 0);
        u_if.key_in = 1'b0;
        rst = 1'b1;
        tick(10);

        // Clean press: key up at cycle 0, down at cycle 40.
        u_if.key_in = 1'b1;
        tick(6);
        check("clean_not_yet", int'(u_if.is_pressing), 0);
        check("clean_pt_before", int'(u_if.press_time), 0);
        tick(1);
        check("clean_rise", int'(u_if.is_pressing), 1);
        check("clean_pt_entry", int'(u_if.press_time), 1);
        tick(33);
        check("clean_pt_c40", int'(u_if.press_time), 5);
        u_if.key_in = 1'b0;
        tick(6);
        check("clean_held_c46", int'(u_if.is_pressing), 1);
        check("clean_nopulse_c46", int'(u_if.release_pulse), 0);
        tick(1);
        check("clean_fall_c47", int'(u_if.is_pressing), 0);
        check("clean_pulse_c47", int'(u_if.release_pulse), 1);
        check("clean_pt_c47", int'(u_if.press_time), 6);
        tick(1);
        check("clean_pulse_gone", int'(u_if.release_pulse), 0);
        check("clean_pt_hold", int'(u_if.press_time), 6);
        tick(5);

        // Glitch shorter than the debounce window.
        u_if.key_in = 1'b1;
        tick(3);
        u_if.key_in = 1'b0;
        tick(12);
        check("glitch_is_pressing", int'(u_if.is_pressing), 0);
        check("glitch_pt", int'(u_if.press_time), 6);

        // Saturation: 200-cycle hold.
        u_if.key_in = 1'b1;
        tick(118);
        check("sat_pt_14", int'(u_if.press_time), 14);
        tick(1);
        check("sat_pt_15", int'(u_if.press_time), 15);
        tick(81);
        check("sat_pt_stay", int'(u_if.press_time), 15);
        u_if.key_in = 1'b0;
        tick(10);
        check("sat_released", int'(u_if.is_pressing), 0);
        check("sat_pt_hold", int'(u_if.press_time), 15);

        // Freeze rejects the press even after it drops while held.
        u_if.freeze = 1'b1;
        u_if.key_in = 1'b1;
        tick(12);
        check("frz_blocked", int'(u_if.is_pressing), 0);
        u_if.freeze = 1'b0;
        tick(8);
        check("frz_still_blocked", int'(u_if.is_pressing), 0);
        check("frz_pt_hold", int'(u_if.press_time), 15);
        u_if.key_in = 1'b0;
        tick(10);
        u_if.key_in = 1'b1;
        tick(7);
        check("frz_new_press", int'(u_if.is_pressing), 1);
        check("frz_new_pt", int'(u_if.press_time), 1);

        // Reset in the middle of a charge.
        tick(16);
        check("mid_pt_3", int'(u_if.press_time), 3);
        rst = 1'b0;
        #1;
        check("mid_rst_is_pressing", int'(u_if.is_pressing), 0);
        check("mid_rst_pt", int'(u_if.press_time), 0);
        check("mid_rst_pulse", int'(u_if.release_pulse), 0);
        tick(1);
        for (int i = 0; i < 6; i++) begin
            u_if.key_in = ~u_if.key_in;
            tick(1);
        end
        u_if.key_in = 1'b0;
        rst = 1'b1;
        tick(20);
        check("post_rst_idle", int'(u_if.is_pressing), 0);

        done = 1;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
